// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational SIMD ALU between NUM_REQ requesters.
// Optional busy-cycle counter enabled by `define ALU_BUSY_CNT_EN.
module alu_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_op0,
    input  logic [NUM_REQ*DATA_W-1:0] req_op1,
    input  logic [NUM_REQ*2-1:0]      req_mode,
    output logic [DATA_W-1:0]         alu_op0_value,
    output logic [DATA_W-1:0]         alu_op1_value,
    output logic [1:0]                alu_mode,
    input  logic [DATA_W-1:0]         alu_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic [CNT_W-1:0]          busy_cycles
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [DATA_W-1:0] r_rsp_data;
    logic [ID_W-1:0]   r_rsp_id;
    logic              w_can_issue;
    logic              w_grant_any;
    logic [ID_W-1:0]   w_grant_idx;
    logic [ID_W:0]     w_idx;

    assign w_can_issue = (r_state == EMPTY) || rsp_ready;

    // Search rr_ptr, rr_ptr+1, ... with wrap; first valid requester wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
            if (w_idx >= (ID_W+1)'(NUM_REQ))
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            if (w_can_issue && !w_grant_any && req_valid[w_idx[ID_W-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready     = '0;
        alu_op0_value = '0;
        alu_op1_value = '0;
        alu_mode      = 2'b00;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_grant_any && (w_grant_idx == ID_W'(k))) begin
                req_ready[k]  = 1'b1;
                alu_op0_value = req_op0[k*DATA_W +: DATA_W];
                alu_op1_value = req_op1[k*DATA_W +: DATA_W];
                alu_mode      = req_mode[k*2 +: 2];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY:   if (w_grant_any) w_state_next = FULL;
            FULL:    if (rsp_ready && !w_grant_any) w_state_next = EMPTY;
            default: w_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_rr_ptr   <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_any) begin
                r_rsp_data <= alu_out;
                r_rsp_id   <= w_grant_idx;
                r_rr_ptr   <= (w_grant_idx == ID_W'(NUM_REQ-1)) ? '0 : w_grant_idx + ID_W'(1);
            end
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

`ifdef ALU_BUSY_CNT_EN
    logic [CNT_W-1:0] r_busy_cycles;

    // Saturating: stops at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_busy_cycles <= '0;
        else if (w_grant_any && (r_busy_cycles != '1))
            r_busy_cycles <= r_busy_cycles + CNT_W'(1);
    end

    assign busy_cycles = r_busy_cycles;
`else
    assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed testbench for alu_rr_scheduler with a reference ALU and a response scoreboard.
module tb_alu_rr_scheduler;

    localparam int NR = 4;
    localparam int DW = 256;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_op0;
    logic [NR*DW-1:0] req_op1;
    logic [NR*2-1:0]  req_mode;
    logic [DW-1:0]    alu_op0_value;
    logic [DW-1:0]    alu_op1_value;
    logic [1:0]       alu_mode;
    logic [DW-1:0]    alu_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic [1:0]       rsp_id;
    logic [31:0]      busy_cycles;

    logic [DW-1:0] t_op0 [NR];
    logic [DW-1:0] t_op1 [NR];
    logic [1:0]    t_mode[NR];

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t       q[$];
    int         tests;
    int         fails;
    int         m_ptr;
    int         m_busy;
    logic       m_full;
    logic [1:0] m_last_id;

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < DW/8; l++) begin
            case (m)
                2'b00:   r[l*8 +: 8] = a[l*8 +: 8] + b[l*8 +: 8];
                2'b01:   r[l*8 +: 8] = a[l*8 +: 8] & b[l*8 +: 8];
                2'b10:   r[l*8 +: 8] = a[l*8 +: 8] | b[l*8 +: 8];
                default: r[l*8 +: 8] = a[l*8 +: 8] ^ b[l*8 +: 8];
            endcase
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        return {(DW/8){b}};
    endfunction

    assign alu_out = alu_fn(alu_op0_value, alu_op1_value, alu_mode);
    assign req_op0 = {t_op0[3], t_op0[2], t_op0[1], t_op0[0]};
    assign req_op1 = {t_op1[3], t_op1[2], t_op1[1], t_op1[0]};
    assign req_mode = {t_mode[3], t_mode[2], t_mode[1], t_mode[0]};

    alu_rr_scheduler #(
        .NUM_REQ(NR),
        .DATA_W (DW),
        .ID_W   (2),
        .CNT_W  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op0      (req_op0),
        .req_op1      (req_op1),
        .req_mode     (req_mode),
        .alu_op0_value(alu_op0_value),
        .alu_op1_value(alu_op1_value),
        .alu_mode     (alu_mode),
        .alu_out      (alu_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_id       (rsp_id),
        .busy_cycles  (busy_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_busy();
`ifdef ALU_BUSY_CNT_EN
        return 32'(m_busy);
`else
        return 32'd0;
`endif
    endfunction

    // One clock of stimulus: check combinational grant/ALU drive, update model, check response after edge.
    task automatic step(input logic [NR-1:0] v, input logic rr);
        logic       can;
        logic       found;
        int         g;
        int         idx;
        logic [3:0] exp_ready;
        req_valid = v;
        rsp_ready = rr;
        #1;
        can   = !m_full || rr;
        found = 1'b0;
        g     = 0;
        for (int i = 0; i < NR; i++) begin
            idx = (m_ptr + i) % NR;
            if (can && !found && v[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        exp_ready = found ? (4'b0001 << g) : 4'b0000;
        check("req_ready", DW'(req_ready), DW'(exp_ready));
        check("alu_op0", alu_op0_value, found ? t_op0[g] : '0);
        check("alu_op1", alu_op1_value, found ? t_op1[g] : '0);
        check("alu_mode", DW'(alu_mode), found ? DW'(t_mode[g]) : '0);
        if (m_full && rr)
            void'(q.pop_front());
        if (found) begin
            rsp_t e;
            e.id   = 2'(g);
            e.data = alu_fn(t_op0[g], t_op1[g], t_mode[g]);
            q.push_back(e);
            m_ptr     = (g + 1) % NR;
            m_busy++;
            m_last_id = 2'(g);
        end
        m_full = (q.size() != 0);
        @(posedge clk);
        #1;
        check("rsp_valid", DW'(rsp_valid), DW'(m_full));
        check("rsp_id", DW'(rsp_id), DW'(m_last_id));
        if (m_full)
            check("rsp_data", rsp_data, q[0].data);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        m_ptr     = 0;
        m_busy    = 0;
        m_full    = 1'b0;
        m_last_id = 2'd0;
        clk       = 1'b0;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int k = 0; k < NR; k++) begin
            t_op0[k]  = '0;
            t_op1[k]  = '0;
            t_mode[k] = 2'b00;
        end
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_rsp_valid", DW'(rsp_valid), '0);
        check("reset_rsp_data", rsp_data, '0);
        check("reset_rsp_id", DW'(rsp_id), '0);
        check("reset_busy", DW'(busy_cycles), '0);

        // Single request: 0xFF + 0x02 wraps to 0x01 per lane
        t_op0[0] = fill(8'hFF);
        t_op1[0] = fill(8'h02);
        step(4'b0001, 1'b1);
        check("single_lanes", rsp_data, fill(8'h01));
        step(4'b0000, 1'b1);

        // Round-robin over all four requesters with varied operands
        for (int k = 0; k < NR; k++) begin
            t_op0[k]  = {8{$urandom}};
            t_op1[k]  = {8{$urandom}};
            t_mode[k] = 2'(k);
        end
        for (int c = 0; c < 8; c++)
            step(4'b1111, 1'b1);
        check("rr_busy", DW'(busy_cycles), DW'(exp_busy()));

        // Backpressure: result held, no grants, then release grants requester 1
        for (int c = 0; c < 5; c++)
            step(4'b0110, 1'b0);
        step(4'b0110, 1'b1);
        check("bp_grant_id", DW'(rsp_id), DW'(2'd1));
        step(4'b0000, 1'b1);

        // Wrap and skip: move pointer to 3, then 0101 -> 0, 2, 0
        step(4'b0100, 1'b1);
        step(4'b0101, 1'b1);
        step(4'b0101, 1'b1);
        step(4'b0101, 1'b1);
        check("wrap_last_id", DW'(rsp_id), DW'(2'd0));
        step(4'b0000, 1'b1);

        // Modes 01/10/11 on requesters 1..3
        for (int k = 1; k < NR; k++) begin
            t_op0[k]  = fill(8'hF0);
            t_op1[k]  = fill(8'h3C);
            t_mode[k] = 2'(k);
        end
        step(4'b0010, 1'b1);
        check("mode_and", rsp_data, fill(8'h30));
        step(4'b0100, 1'b1);
        check("mode_or", rsp_data, fill(8'hFC));
        step(4'b1000, 1'b1);
        check("mode_xor", rsp_data, fill(8'hCC));
        step(4'b0000, 1'b1);

        // Reset while FULL and stalled
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", DW'(rsp_valid), '0);
        check("async_rst_busy", DW'(busy_cycles), '0);
        q.delete();
        m_ptr     = 0;
        m_busy    = 0;
        m_full    = 1'b0;
        m_last_id = 2'd0;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(4'b1010, 1'b1);
        check("post_rst_id", DW'(rsp_id), DW'(2'd1));
        step(4'b1111, 1'b1);
        check("post_rst_rr_id", DW'(rsp_id), DW'(2'd2));
        check("post_rst_busy", DW'(busy_cycles), DW'(exp_busy()));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
